// File: rtl/program_loader.sv
// Streams a program image into byte RAM from address 0 and records where the code section starts.
// Optional feature: define LOADER_CHECKSUM_EN to accumulate a mod-256 sum of accepted bytes.
module program_loader #(
  parameter int         ADDR_W    = 23,
  parameter int         MEM_BYTES = 8000000,
  parameter logic [7:0] MARKER    = 8'd14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_data,
  input  logic              byte_valid,
  input  logic              byte_last,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic              mem_wait,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              code_found,
  output logic [ADDR_W-1:0] code_start,
  output logic [ADDR_W-1:0] byte_count,
  output logic [7:0]        checksum
);
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_FLUSH, ST_DONE, ST_ERROR} state_t;

  localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_BYTES);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] byte_count_q, byte_count_d;
  logic              code_found_q, code_found_d;
  logic [ADDR_W-1:0] code_start_q, code_start_d;
  logic              stalled, room, accept, restart;

  assign stalled    = mem_we_q & mem_wait;
  assign room       = byte_count_q < MEM_LIMIT;
  assign byte_ready = (state_q == ST_LOAD) & room & ~stalled;
  assign accept     = byte_valid & byte_ready;
  assign restart    = start & ((state_q == ST_IDLE) | (state_q == ST_DONE) | (state_q == ST_ERROR));

  always_comb begin
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = mem_we_q;
    byte_count_d = byte_count_q;
    code_found_d = code_found_q;
    code_start_d = code_start_q;

    // The write register is independent of state so a stalled write still retires in ERROR.
    if (accept) begin
      mem_addr_d   = byte_count_q;
      mem_wdata_d  = byte_data;
      mem_we_d     = 1'b1;
      byte_count_d = byte_count_q + ADDR_W'(1);
      if (!code_found_q && (byte_data == MARKER)) begin
        code_found_d = 1'b1;
        code_start_d = byte_count_q + ADDR_W'(1);
      end
    end else if (!stalled) begin
      mem_we_d = 1'b0;
    end

    if (restart) begin
      byte_count_d = '0;
      code_found_d = 1'b0;
      code_start_d = '0;
    end

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: if (start) state_d = ST_LOAD;
      ST_LOAD: begin
        if (accept && byte_last)     state_d = ST_FLUSH;
        else if (byte_valid && !room) state_d = ST_ERROR;
      end
      ST_FLUSH: if (mem_we_q && !mem_wait) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      byte_count_q <= '0;
      code_found_q <= 1'b0;
      code_start_q <= '0;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      byte_count_q <= byte_count_d;
      code_found_q <= code_found_d;
      code_start_q <= code_start_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (restart)     checksum_d = 8'd0;
    else if (accept) checksum_d = checksum_q + byte_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) checksum_q <= 8'd0;
    else     checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`else
  assign checksum = 8'd0;
`endif

  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = mem_we_q;
  assign busy       = (state_q == ST_LOAD) | (state_q == ST_FLUSH);
  assign done       = (state_q == ST_DONE);
  assign error      = (state_q == ST_ERROR);
  assign code_found = code_found_q;
  assign code_start = code_start_q;
  assign byte_count = byte_count_q;
endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: a full-size instance and a 4-byte instance, driven by a table and random streams.
module tb_program_loader;
  localparam int         AW        = 23;
  localparam int         MEM_BIG   = 8000000;
  localparam int         MEM_SMALL = 4;
  localparam logic [7:0] MARK      = 8'd14;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]         start_s, byte_valid_s, byte_last_s, mem_wait_s;
  logic [1:0][7:0]    byte_data_s;
  logic [1:0]         byte_ready_s, mem_we_s, busy_s, done_s, error_s, code_found_s;
  logic [1:0][AW-1:0] mem_addr_s, code_start_s, byte_count_s;
  logic [1:0][7:0]    mem_wdata_s, checksum_s;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      program_loader #(
        .ADDR_W(AW), .MEM_BYTES(gi == 0 ? MEM_BIG : MEM_SMALL), .MARKER(MARK)
      ) dut (
        .clk(clk), .rst(rst), .start(start_s[gi]),
        .byte_data(byte_data_s[gi]), .byte_valid(byte_valid_s[gi]), .byte_last(byte_last_s[gi]),
        .byte_ready(byte_ready_s[gi]), .mem_addr(mem_addr_s[gi]), .mem_wdata(mem_wdata_s[gi]),
        .mem_we(mem_we_s[gi]), .mem_wait(mem_wait_s[gi]), .busy(busy_s[gi]), .done(done_s[gi]),
        .error(error_s[gi]), .code_found(code_found_s[gi]), .code_start(code_start_s[gi]),
        .byte_count(byte_count_s[gi]), .checksum(checksum_s[gi])
      );
    end
  endgenerate

  int vectors;
  int miscompares;
  logic [7:0] stim [0:63];
  logic [7:0] ram_seen [int];

  typedef struct packed {
    int           sel;
    int           n;
    bit           last;
    logic [127:0] data;
    int           wait_pct;
    int           stall_addr;
    int           mid_start;
    bit           e_done;
    bit           e_err;
    bit           e_found;
    int           e_start;
    int           e_count;
    logic [7:0]   e_sum;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input int sel);
    chk("z_busy",       32'(busy_s[sel]),       32'd0);
    chk("z_done",       32'(done_s[sel]),       32'd0);
    chk("z_error",      32'(error_s[sel]),      32'd0);
    chk("z_code_found", 32'(code_found_s[sel]), 32'd0);
    chk("z_code_start", 32'(code_start_s[sel]), 32'd0);
    chk("z_byte_count", 32'(byte_count_s[sel]), 32'd0);
    chk("z_checksum",   32'(checksum_s[sel]),   32'd0);
    chk("z_mem_we",     32'(mem_we_s[sel]),     32'd0);
    chk("z_mem_addr",   32'(mem_addr_s[sel]),   32'd0);
    chk("z_mem_wdata",  32'(mem_wdata_s[sel]),  32'd0);
    chk("z_byte_ready", 32'(byte_ready_s[sel]), 32'd0);
  endtask

  // Reference: the first min(n, capacity) bytes land at addresses 0.., anything beyond is an overflow.
  function automatic void model(input int mem_bytes, input int n, output bit e_done, output bit e_err,
                                output bit e_found, output int e_start, output int e_count,
                                output logic [7:0] e_sum);
    e_count = (n > mem_bytes) ? mem_bytes : n;
    e_err   = (n > mem_bytes);
    e_done  = !e_err;
    e_found = 1'b0;
    e_start = 0;
    e_sum   = 8'd0;
    for (int i = 0; i < e_count; i++) begin
      e_sum = e_sum + stim[i];
      if (!e_found && stim[i] == MARK) begin
        e_found = 1'b1;
        e_start = i + 1;
      end
    end
  endfunction

  task automatic run_stream(input int sel, input int n, input bit last, input int wait_pct,
                            input int stall_addr, input int mid_start, input bit e_done,
                            input bit e_err, input bit e_found, input int e_start,
                            input int e_count, input logic [7:0] e_sum);
    int idx, cyc, tail, stall_cnt, retired, pend_idx;
    bit ended, pend_acc, hold, stalled_once, mid_done;
    logic [AW-1:0] hold_addr;
    logic [7:0]    hold_data, exp_sum;
    idx = 0; cyc = 0; tail = 3; stall_cnt = 0; retired = 0; pend_idx = 0;
    ended = 0; pend_acc = 0; hold = 0; stalled_once = 0; mid_done = 0;
    hold_addr = '0; hold_data = '0;
    ram_seen.delete();

    @(negedge clk);
    start_s[sel] = 1'b1; byte_valid_s[sel] = 1'b0; byte_last_s[sel] = 1'b0; mem_wait_s[sel] = 1'b0;
    @(negedge clk);
    start_s[sel] = 1'b0;

    while (cyc < 3000 && !(ended && tail == 0)) begin
      if (ended) begin
        byte_valid_s[sel] = 1'b0; byte_last_s[sel] = 1'b0; mem_wait_s[sel] = 1'b0; start_s[sel] = 1'b0;
        tail--;
      end else begin
        byte_valid_s[sel] = (idx < n) && (wait_pct == 0 || $urandom_range(99) < 75);
        byte_data_s[sel]  = (idx < n) ? stim[idx] : 8'($urandom);
        byte_last_s[sel]  = last && (idx == n - 1);
        if (stall_cnt > 0) begin
          mem_wait_s[sel] = 1'b1;
          stall_cnt--;
        end else if (stall_addr >= 0 && !stalled_once && mem_we_s[sel] && mem_addr_s[sel] == AW'(stall_addr)) begin
          mem_wait_s[sel] = 1'b1;
          stall_cnt = 2;
          stalled_once = 1'b1;
        end else begin
          mem_wait_s[sel] = (wait_pct > 0) && ($urandom_range(99) < wait_pct);
        end
        start_s[sel] = (mid_start >= 0) && (idx == mid_start) && !mid_done;
        if (start_s[sel]) mid_done = 1'b1;
      end

      #4;
      if (pend_acc) begin
        chk("wr_we",   32'(mem_we_s[sel]),    32'd1);
        chk("wr_addr", 32'(mem_addr_s[sel]),  32'(pend_idx));
        chk("wr_data", 32'(mem_wdata_s[sel]), 32'(stim[pend_idx]));
        pend_acc = 1'b0;
      end
      if (hold) begin
        chk("hold_we",   32'(mem_we_s[sel]),    32'd1);
        chk("hold_addr", 32'(mem_addr_s[sel]),  32'(hold_addr));
        chk("hold_data", 32'(mem_wdata_s[sel]), 32'(hold_data));
      end
      hold = mem_we_s[sel] && mem_wait_s[sel];
      if (hold) begin
        chk("stall_ready", 32'(byte_ready_s[sel]), 32'd0);
        hold_addr = mem_addr_s[sel];
        hold_data = mem_wdata_s[sel];
      end
      if (mem_we_s[sel] && !mem_wait_s[sel]) begin
        retired++;
        ram_seen[int'(mem_addr_s[sel])] = mem_wdata_s[sel];
      end
      if (byte_valid_s[sel] && byte_ready_s[sel]) begin
        pend_acc = 1'b1;
        pend_idx = idx;
        idx++;
      end
      @(posedge clk);
      #1;
      if (!ended && (done_s[sel] || error_s[sel])) ended = 1'b1;
      @(negedge clk);
      cyc++;
    end
    byte_valid_s[sel] = 1'b0; byte_last_s[sel] = 1'b0; mem_wait_s[sel] = 1'b0; start_s[sel] = 1'b0;

    exp_sum = e_sum;
`ifndef LOADER_CHECKSUM_EN
    exp_sum = 8'd0;
`endif
    chk("finished",   32'(ended),              32'd1);
    chk("done",       32'(done_s[sel]),        32'(e_done));
    chk("error",      32'(error_s[sel]),       32'(e_err));
    chk("busy",       32'(busy_s[sel]),        32'd0);
    chk("code_found", 32'(code_found_s[sel]),  32'(e_found));
    chk("code_start", 32'(code_start_s[sel]),  32'(e_start));
    chk("byte_count", 32'(byte_count_s[sel]),  32'(e_count));
    chk("checksum",   32'(checksum_s[sel]),    32'(exp_sum));
    chk("writes",     32'(retired),            32'(e_count));
    for (int i = 0; i < e_count; i++)
      chk("ram", ram_seen.exists(i) ? 32'(ram_seen[i]) : 32'hFFFF_FFFF, 32'(stim[i]));
    $display("stream sel=%0d n=%0d last=%0d cycles=%0d: done=%0d error=%0d code_start=%0d byte_count=%0d checksum=0x%0h",
             sel, n, last, cyc, done_s[sel], error_s[sel], code_start_s[sel], byte_count_s[sel], checksum_s[sel]);
  endtask

  task automatic reset_mid_load();
    @(negedge clk);
    start_s[0] = 1'b1; mem_wait_s[0] = 1'b0;
    @(negedge clk);
    start_s[0] = 1'b0;
    byte_valid_s[0] = 1'b1; byte_data_s[0] = 8'h31; byte_last_s[0] = 1'b0;
    @(negedge clk);
    byte_data_s[0] = 8'h32;
    chk("pre_rst_busy",  32'(busy_s[0]),       32'd1);
    chk("pre_rst_count", 32'(byte_count_s[0]), 32'd1);
    #2 rst = 1'b1;
    #1 check_zero(0);
    @(posedge clk);
    #1 check_zero(0);
    @(negedge clk);
    rst = 1'b0;
    byte_valid_s[0] = 1'b0;
    $display("reset mid-load applied on sel=0");
  endtask

  initial begin
    int sel, n, mb;
    bit last, e_done, e_err, e_found;
    int e_start, e_count;
    logic [7:0] e_sum;
    logic [127:0] d;

    vectors = 0; miscompares = 0;
    rst = 1'b1;
    start_s = '0; byte_last_s = '0; mem_wait_s = '0; byte_data_s = '0;
    byte_valid_s = '1;
    repeat (2) @(negedge clk);
    check_zero(0); check_zero(1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_zero(0); check_zero(1);
    byte_valid_s = '0;
    $display("reset and idle checks done");

    //           sel n  last data                       wait stall mid done err found start cnt sum
    tbl[0] = '{0, 4,  1'b1, 128'hAA0E0201,              0,   -1,  -1, 1'b1, 1'b0, 1'b1, 3, 4,  8'hBB};
    tbl[1] = '{0, 10, 1'b1, 128'h0E776655_0E443322_1100, 20,  -1,  4,  1'b1, 1'b0, 1'b1, 6, 10, 8'hF8};
    tbl[2] = '{0, 6,  1'b1, 128'h060504030201,          0,   2,   -1, 1'b1, 1'b0, 1'b0, 0, 6,  8'h15};
    tbl[3] = '{1, 5,  1'b0, 128'h5040302010,            0,   -1,  -1, 1'b0, 1'b1, 1'b0, 0, 4,  8'hA0};
    tbl[4] = '{1, 4,  1'b1, 128'h0E030201,              30,  -1,  -1, 1'b1, 1'b0, 1'b1, 4, 4,  8'h14};
    tbl[5] = '{0, 3,  1'b1, 128'h070605,                50,  -1,  -1, 1'b1, 1'b0, 1'b0, 0, 3,  8'h12};
    tbl[6] = '{1, 5,  1'b0, 128'h040302010E,            30,  -1,  -1, 1'b0, 1'b1, 1'b1, 1, 4,  8'h14};

    for (int k = 0; k < 7; k++) begin
      if (k == 5) reset_mid_load();
      d = tbl[k].data;
      for (int i = 0; i < 16; i++) stim[i] = d[8*i +: 8];
      run_stream(tbl[k].sel, tbl[k].n, tbl[k].last, tbl[k].wait_pct, tbl[k].stall_addr,
                 tbl[k].mid_start, tbl[k].e_done, tbl[k].e_err, tbl[k].e_found,
                 tbl[k].e_start, tbl[k].e_count, tbl[k].e_sum);
    end

    for (int r = 0; r < 16; r++) begin
      sel  = r % 2;
      mb   = (sel == 0) ? MEM_BIG : MEM_SMALL;
      n    = (sel == 0) ? int'($urandom_range(40, 1)) : int'($urandom_range(6, 1));
      last = (n <= mb);
      for (int i = 0; i < n; i++) stim[i] = ($urandom_range(4) == 0) ? MARK : 8'($urandom);
      model(mb, n, e_done, e_err, e_found, e_start, e_count, e_sum);
      run_stream(sel, n, last, 30, -1, -1, e_done, e_err, e_found, e_start, e_count, e_sum);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
